hd63701_phase_seq: RTL

- Phase sequencer for the HD63701 core; sits directly upstream of the microcode ROM.
- Generates the 6-bit PHASE code and the latched OPCODE that select the microcode word.
- Arbitrates reset, NMI, IRQ, SWI, TRAP and SLEEP entry, and supplies the vector select used by the vector-load phases.
- Takes end/exception strobes back from the microcode executor.

---
 rtl/hd63701_phase_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hd63701_phase_seq.sv
// HD63701 phase sequencer: produces the PHASE/OPCODE pair that addresses the
// microcode ROM, arbitrates reset/NMI/IRQ/SWI/TRAP/SLEEP and drives VECSEL.
module hd63701_phase_seq #(
  parameter logic [7:0] NOP_OP = 8'h01
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       EN,
  input  logic [7:0] DIN,
  input  logic       MCEND,
  input  logic       MCSWI,
  input  logic       MCTRAP,
  input  logic       MCSLP,
  input  logic       IFLAG,
  input  logic       NMI,
  input  logic       IRQ1,
  input  logic       IRQ2,
  output logic [5:0] PHASE,
  output logic [7:0] OPCODE,
  output logic       MCEN,
  output logic [2:0] VECSEL,
  output logic       INTACK
);

  typedef enum logic [5:0] {
    phRST   = 6'd0,  phVECT  = 6'd1,  phVEC1  = 6'd2,  phVEC2  = 6'd3,
    phFETCH = 6'd4,
    phEXEC  = 6'd16, phEXEC1 = 6'd17, phEXEC2 = 6'd18, phEXEC3 = 6'd19,
    phEXEC4 = 6'd20, phEXEC5 = 6'd21, phEXEC6 = 6'd22, phEXEC7 = 6'd23,
    phEXEC8 = 6'd24, phEXEC9 = 6'd25,
    phINTR  = 6'd32, phINTR1 = 6'd33, phINTR2 = 6'd34, phINTR3 = 6'd35,
    phINTR4 = 6'd36, phINTR5 = 6'd37, phINTR6 = 6'd38, phINTR7 = 6'd39,
    phINTR8 = 6'd40, phINTR9 = 6'd41,
    phSLEEP = 6'd48, phHALT  = 6'd63
  } phase_t;

  localparam logic [2:0] V_RST = 3'd0, V_NMI = 3'd1, V_SWI = 3'd2,
                         V_IRQ1 = 3'd3, V_IRQ2 = 3'd4, V_TRAP = 3'd5;

  phase_t     ph, ph_nxt;
  logic [7:0] opc_nxt;
  logic [2:0] vs_nxt;
  logic       ack_nxt;
  logic       nmi_q, nmi_pend, pend_clr, nmi_edge;
  logic       irq1_ok, irq2_ok;

  assign PHASE    = ph;
  assign MCEN     = EN;
  assign nmi_edge = NMI & ~nmi_q;
  assign irq1_ok  = IRQ1 & ~IFLAG;
  assign irq2_ok  = IRQ2 & ~IFLAG;

  // Next phase, opcode latch, vector select and ack pulse.
  always_comb begin
    ph_nxt   = ph;
    opc_nxt  = OPCODE;
    vs_nxt   = VECSEL;
    ack_nxt  = 1'b0;
    pend_clr = 1'b0;
    case (ph)
      phRST: begin
        ph_nxt  = phVECT;
        vs_nxt  = V_RST;
        ack_nxt = 1'b1;
      end
      phVECT: ph_nxt = phVEC1;
      phVEC1: ph_nxt = phVEC2;
      phVEC2: ph_nxt = phFETCH;
      // Fetch and sleep share the interrupt check; only fetch loads an opcode.
      phFETCH, phSLEEP: begin
        if (nmi_pend) begin
          ph_nxt   = phINTR;
          vs_nxt   = V_NMI;
          pend_clr = 1'b1;
        end else if (irq1_ok) begin
          ph_nxt = phINTR;
          vs_nxt = V_IRQ1;
        end else if (irq2_ok) begin
          ph_nxt = phINTR;
          vs_nxt = V_IRQ2;
        end else if (ph == phFETCH) begin
          opc_nxt = DIN;
          ph_nxt  = phEXEC;
        end
      end
      phEXEC, phEXEC1, phEXEC2, phEXEC3, phEXEC4,
      phEXEC5, phEXEC6, phEXEC7, phEXEC8, phEXEC9: begin
        if (MCTRAP) begin
          ph_nxt = phINTR;
          vs_nxt = V_TRAP;
        end else if (MCSWI) begin
          ph_nxt = phINTR;
          vs_nxt = V_SWI;
        end else if (MCSLP) begin
          ph_nxt = phSLEEP;
        end else if (MCEND) begin
          ph_nxt = phFETCH;
        end else if (ph == phEXEC9) begin
          ph_nxt = phHALT;
        end else begin
          ph_nxt = phase_t'(ph + 6'd1);
        end
      end
      phINTR, phINTR1, phINTR2, phINTR3, phINTR4, phINTR5, phINTR6:
        ph_nxt = phase_t'(ph + 6'd1);
      phINTR7: begin
        ph_nxt  = phVECT;
        ack_nxt = 1'b1;
      end
      // phHALT and the unused INTR8/9 codes park until reset.
      default: ph_nxt = phHALT;
    endcase
  end

  // State registers; a new NMI edge beats a same-cycle pending clear.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ph       <= phRST;
      OPCODE   <= NOP_OP;
      VECSEL   <= V_RST;
      INTACK   <= 1'b0;
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
    end else if (EN) begin
      ph       <= ph_nxt;
      OPCODE   <= opc_nxt;
      VECSEL   <= vs_nxt;
      INTACK   <= ack_nxt;
      nmi_q    <= NMI;
      nmi_pend <= nmi_edge | (nmi_pend & ~pend_clr);
    end else begin
      INTACK   <= 1'b0;
    end
  end

endmodule
